// File: rtl/crc_pkg.sv
// Shared types and helpers for the CRC input buffer: bus/reversal encodings,
// serializer states and the push-time bit reversal.
package crc_pkg;

  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} bus_size_e;
  typedef enum logic [1:0] {REV_NONE, REV_BYTE, REV_HALF, REV_WORD} rev_type_e;
  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} inbuf_state_e;

  // FIFO entry: {32-bit data, index of the word's final byte}
  localparam int ENTRY_W = 34;

  function automatic logic [31:0] bit_reverse(input logic [31:0] data, input rev_type_e rev_type);
    logic [31:0] r;
    r = data;
    case (rev_type)
      REV_BYTE: for (int i = 0; i < 32; i++) r[i] = data[(i & ~7) + 7 - (i & 7)];
      REV_HALF: for (int i = 0; i < 32; i++) r[i] = data[(i & ~15) + 15 - (i & 15)];
      REV_WORD: for (int i = 0; i < 32; i++) r[i] = data[31 - i];
      default:  r = data;
    endcase
    return r;
  endfunction

  // Size 2'b11 is treated as a full word.
  function automatic logic [1:0] last_index(input logic [1:0] size);
    case (size)
      BYTE:    return 2'd0;
      HALF:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] keep_mask(input logic [1:0] last_idx);
    case (last_idx)
      2'd0:    return 32'h0000_00ff;
      2'd1:    return 32'h0000_ffff;
      default: return 32'hffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/crc_word_fifo.sv
// Synchronous DEPTH-entry word FIFO with flush; head entry is visible on dout
// whenever the FIFO is non-empty.
module crc_word_fifo
  import crc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = ENTRY_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/crc_input_buffer.sv
// CRC_DR write buffer and byte serializer feeding the CRC compute unit.
// Define CRC_INBUF_OVF_EN to get the sticky overflow flag on dropped writes.
module crc_input_buffer
  import crc_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [DATA_W-1:0] bus_wr,
  input  logic [1:0]        bus_size,
  input  logic [1:0]        rev_in_type,
  input  logic              buffer_write_en,
  input  logic              reset_chain,
  input  logic              byte_ready,
  output logic              buffer_full,
  output logic              read_wait,
  output logic              reset_pending,
  output logic [7:0]        crc_byte,
  output logic              byte_valid,
  output logic              byte_last,
  output logic              crc_clear,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  inbuf_state_e          state;
  logic [31:0]           shift;
  logic [1:0]            byte_cnt;
  logic [1:0]            last_idx;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head;
  logic [$clog2(DEPTH):0] count;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  word_done;

  assign last_idx   = last_index(bus_size);
  assign push_entry = {bit_reverse(bus_wr, rev_type_e'(rev_in_type)) & keep_mask(last_idx), last_idx};
  // Flush wins over a simultaneous write; a full FIFO rejects even if it pops this cycle.
  assign push       = buffer_write_en && !buffer_full && !reset_chain;
  assign word_done  = (state == SHIFT) && byte_ready && (byte_cnt == 2'd0);
  assign pop        = !reset_chain && !fifo_empty && ((state == IDLE) || word_done);

  crc_word_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (push),
    .pop   (pop),
    .flush (reset_chain),
    .din   (push_entry),
    .dout  (head),
    .count (count),
    .full  (buffer_full),
    .empty (fifo_empty)
  );

  // Byte stream handshake: a byte moves when byte_valid && byte_ready at a rising
  // edge; crc_byte/byte_last hold stable while byte_valid is high and byte_ready low.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= IDLE;
      shift    <= '0;
      byte_cnt <= '0;
    end else if (reset_chain) begin
      state    <= FLUSH;
      shift    <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= head[ENTRY_W-1:2];
            byte_cnt <= head[1:0];
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (byte_ready) begin
            if (pop) begin
              shift    <= head[ENTRY_W-1:2];
              byte_cnt <= head[1:0];
            end else begin
              shift    <= shift >> 8;
              byte_cnt <= (byte_cnt == 2'd0) ? 2'd0 : byte_cnt - 2'd1;
              if (byte_cnt == 2'd0) state <= IDLE;
            end
          end
        end
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign crc_byte      = shift[7:0];
  assign byte_valid    = (state == SHIFT);
  assign byte_last     = byte_valid && (byte_cnt == 2'd0);
  assign reset_pending = (state == FLUSH);
  assign crc_clear     = (state == FLUSH);
  assign read_wait     = (count != '0) || (state != IDLE);
  assign dbg_state     = state;

`ifdef CRC_INBUF_OVF_EN
  always_ff @(posedge HCLK) begin
    if (HRESET || reset_chain) overflow <= 1'b0;
    else if (buffer_write_en && buffer_full) overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
